// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the M-extension execute unit: funct3 op codes, FSM states
// and word constants sized for the widest legal XLEN.
package ex_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Constants are MSB-aligned at XLEN_MAX so a top slice [XLEN_MAX-1 -: XLEN]
  // yields the right value for either legal XLEN.
  localparam int XLEN_MAX = 64;
  localparam logic [XLEN_MAX-1:0] ZERO_WORD  = '0;
  localparam logic [XLEN_MAX-1:0] ALL_ONES   = '1;
  localparam logic [XLEN_MAX-1:0] MIN_SIGNED = {1'b1, {(XLEN_MAX-1){1'b0}}};

endpackage

// File: rtl/ex_div_core.sv
// Restoring-divider datapath on unsigned magnitudes: one quotient bit per step strobe.
// The outputs present the values the registers take on the current step.
module ex_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);

  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dsr_q, dsr_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            fits;

  // The dividend sits in the quotient register and drains MSB-first into the remainder.
  always_comb begin
    shifted   = {rem_q, quo_q[XLEN-1]};
    fits      = shifted >= {1'b0, dsr_q};
    diff      = shifted - {1'b0, dsr_q};
    quo_nxt_o = {quo_q[XLEN-2:0], fits};
    rem_nxt_o = XLEN'(fits ? diff : shifted);

    quo_d = quo_q;
    rem_d = rem_q;
    dsr_d = dsr_q;
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dsr_d = divisor_i;
    end else if (step_i) begin
      quo_d = quo_nxt_o;
      rem_d = rem_nxt_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide execute unit with pipeline hold request.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a one-cycle multiplier.
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      reg_wr_addr_i,
  input  logic            flush_i,
  output logic            hold_o,
  output logic            busy_o,
  output logic            reg_wr_en_o,
  output logic [4:0]      reg_wr_addr_o,
  output logic [XLEN-1:0] reg_wr_data_o
);

  localparam logic [XLEN-1:0] K_ZERO = ZERO_WORD[XLEN_MAX-1 -: XLEN];
  localparam logic [XLEN-1:0] K_ONES = ALL_ONES[XLEN_MAX-1 -: XLEN];
  localparam logic [XLEN-1:0] K_MIN  = MIN_SIGNED[XLEN_MAX-1 -: XLEN];

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] acc_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   data_q, data_d;

  logic              sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_val;
  logic              issue, last_iter;
  logic [XLEN-1:0]   quo_nxt, rem_nxt;

  // Operand decode on the issue-cycle inputs; magnitudes feed both datapaths.
  assign sgn1     = funct3_i inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign sgn2     = funct3_i inside {F3_MULH, F3_DIV, F3_REM};
  assign neg1     = sgn1 & op1_i[XLEN-1];
  assign neg2     = sgn2 & op2_i[XLEN-1];
  assign mag1     = neg1 ? -op1_i : op1_i;
  assign mag2     = neg2 ? -op2_i : op2_i;
  assign div_zero = (op2_i == K_ZERO);
  assign div_ovf  = (funct3_i inside {F3_DIV, F3_REM}) && (op1_i == K_MIN) && (op2_i == K_ONES);
  assign special_val = div_zero ? (funct3_i[1] ? op1_i : K_ONES)
                                : (funct3_i[1] ? K_ZERO : K_MIN);

  assign issue     = (state_q == S_IDLE) && start_i && !flush_i;
  assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
  assign acc_nxt   = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] prod_fast;
  assign prod_fast = {K_ZERO, mag1} * {K_ZERO, mag2};
`endif

  function automatic logic [XLEN-1:0] mul_fix(input logic [2:0] f3, input logic neg,
                                              input logic [2*XLEN-1:0] p);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (f3 == F3_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  ex_div_core #(.XLEN(XLEN)) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .load_i     (issue && funct3_i[2]),
    .step_i     (state_q == S_DIV),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    data_d   = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          funct3_d = funct3_i;
          rd_d     = reg_wr_addr_i;
          cnt_d    = '0;
          if (funct3_i[2]) begin
            if (div_zero || div_ovf) begin
              neg_d   = 1'b0;
              data_d  = special_val;
              state_d = S_DONE;
            end else begin
              neg_d   = funct3_i[1] ? neg1 : (neg1 ^ neg2);
              state_d = S_DIV;
            end
          end else begin
            neg_d = neg1 ^ neg2;
`ifdef MULDIV_FAST_MUL_EN
            data_d  = mul_fix(funct3_i, neg1 ^ neg2, prod_fast);
            state_d = S_DONE;
`else
            mcand_d  = {K_ZERO, mag1};
            mplier_d = mag2;
            acc_d    = '0;
            state_d  = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          data_d  = mul_fix(funct3_q, neg_q, acc_nxt);
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (last_iter) begin
          data_d  = funct3_q[1] ? (neg_q ? -rem_nxt : rem_nxt)
                                : (neg_q ? -quo_nxt : quo_nxt);
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush_i) state_d = S_IDLE;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
    end
  end

  // Hold drops in DONE so the pipeline advances alongside the write-back.
  assign hold_o        = issue || (state_q == S_MUL) || (state_q == S_DIV);
  assign busy_o        = (state_q != S_IDLE);
  assign reg_wr_en_o   = (state_q == S_DONE) && !flush_i;
  assign reg_wr_addr_o = rd_q;
  assign reg_wr_data_o = data_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed ops push expected write-backs,
// a negedge monitor pops and compares data, address and cycle.
module tb_ex_muldiv_unit;
  import ex_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam int ACT_NONE  = 0;
  localparam int ACT_FLUSH = 1;
  localparam int ACT_RST   = 2;
  localparam int ACT_BUSY  = 3;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op1_i, op2_i;
  logic [4:0]  reg_wr_addr_i;
  logic        flush_i;
  logic        hold_o, busy_o, reg_wr_en_o;
  logic [4:0]  reg_wr_addr_o;
  logic [31:0] reg_wr_data_o;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .funct3_i      (funct3_i),
    .op1_i         (op1_i),
    .op2_i         (op2_i),
    .reg_wr_addr_i (reg_wr_addr_i),
    .flush_i       (flush_i),
    .hold_o        (hold_o),
    .busy_o        (busy_o),
    .reg_wr_en_o   (reg_wr_en_o),
    .reg_wr_addr_o (reg_wr_addr_o),
    .reg_wr_data_o (reg_wr_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reg_wr_en_o) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_wb: got data %0h addr %0d, required no write-back (cycle %0d)",
                 reg_wr_data_o, reg_wr_addr_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("wb_data", 64'(reg_wr_data_o), 64'(mon_e.data));
        check("wb_addr", 64'(reg_wr_addr_o), 64'(mon_e.rd));
        check("wb_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Called at #1 after a rising edge; ends at #1 after the edge closing cycle ncyc.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int lat,
                        input bit push, input bit chk_hold, input int act, input int act_cyc,
                        input int ncyc);
    start_i       = 1'b1;
    funct3_i      = f3;
    op1_i         = a;
    op2_i         = b;
    reg_wr_addr_i = rd;
    if (push) exp_q.push_back('{exp, rd, cyc + lat});
    for (int c = 0; c <= ncyc; c++) begin
      @(negedge clk);
      if (chk_hold) check("hold", 64'(hold_o), 64'(c < lat));
      if (act == ACT_FLUSH && c == act_cyc) check("flush_no_wb", 64'(reg_wr_en_o), 64'd0);
      if ((act == ACT_FLUSH || act == ACT_RST) && c == act_cyc + 1) begin
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_hold", 64'(hold_o), 64'd0);
      end
      if (act == ACT_RST && c == act_cyc + 1) begin
        check("rst_wr_en", 64'(reg_wr_en_o), 64'd0);
        check("rst_addr", 64'(reg_wr_addr_o), 64'd0);
        check("rst_data", 64'(reg_wr_data_o), 64'd0);
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
      flush_i = 1'b0;
      rst     = 1'b0;
      if (c + 1 == act_cyc) begin
        case (act)
          ACT_FLUSH: flush_i = 1'b1;
          ACT_RST:   rst = 1'b1;
          ACT_BUSY: begin
            start_i       = 1'b1;
            funct3_i      = F3_DIVU;
            op1_i         = 32'd100;
            op2_i         = 32'd7;
            reg_wr_addr_i = 5'd9;
          end
          default: ;
        endcase
      end
    end
    check("drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] rd, input logic [31:0] exp, input int lat);
    run_op(f3, a, b, rd, exp, lat, 1'b1, 1'b1, ACT_NONE, 0, lat + 1);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    funct3_i = '0;
    op1_i = '0;
    op2_i = '0;
    reg_wr_addr_i = '0;
    flush_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_hold", 64'(hold_o), 64'd0);
    check("reset_wr_en", 64'(reg_wr_en_o), 64'd0);
    check("reset_addr", 64'(reg_wr_addr_o), 64'd0);
    check("reset_data", 64'(reg_wr_data_o), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Multiplies
    op(F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MUL_LAT);
    op(F3_MULH,   32'h80000000, 32'h80000000, 5'd2,  32'h40000000, MUL_LAT);
    op(F3_MULHU,  32'h80000000, 32'h80000000, 5'd3,  32'h40000000, MUL_LAT);
    op(F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, MUL_LAT);
    op(F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, MUL_LAT);
    op(F3_MUL,    32'd3,        32'd4,        5'd6,  32'd12,       MUL_LAT);

    // Divides, including special cases
    op(F3_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h80000000, 1);
    op(F3_REM,  32'h80000000, 32'hFFFFFFFF, 5'd8,  32'h00000000, 1);
    op(F3_REM,  32'hFFFFFFF9, 32'd2,        5'd9,  32'hFFFFFFFF, DIV_LAT);
    op(F3_DIVU, 32'd100,      32'd7,        5'd10, 32'd14,       DIV_LAT);
    op(F3_DIVU, 32'd5,        32'd0,        5'd11, 32'hFFFFFFFF, 1);
    op(F3_REMU, 32'd5,        32'd0,        5'd12, 32'd5,        1);
    op(F3_DIV,  32'hFFFFFFF9, 32'd2,        5'd13, 32'hFFFFFFFD, DIV_LAT);
    op(F3_DIV,  32'd20,       32'hFFFFFFFA, 5'd14, 32'hFFFFFFFD, DIV_LAT);
    op(F3_REM,  32'd20,       32'hFFFFFFFA, 5'd15, 32'd2,        DIV_LAT);
    op(F3_REM,  32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFF9, 1);
    op(F3_REMU, 32'hFFFFFFFF, 32'h10,       5'd17, 32'hF,        DIV_LAT);

    // Flush mid-divide at cycle 10, then a MUL issued in cycle 12
    run_op(F3_DIV, 32'd100, 32'd7, 5'd18, 32'd0, DIV_LAT, 1'b0, 1'b0, ACT_FLUSH, 10, 11);
    op(F3_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd19, 32'd1, MUL_LAT);

    // Flush in DONE suppresses the write-back
    run_op(F3_DIVU, 32'd5, 32'd0, 5'd20, 32'd0, 1, 1'b0, 1'b0, ACT_FLUSH, 1, 2);

    // flush_i together with start_i in IDLE does not issue
    start_i = 1'b1;
    flush_i = 1'b1;
    funct3_i = F3_MUL;
    op1_i = 32'd2;
    op2_i = 32'd2;
    reg_wr_addr_i = 5'd21;
    @(negedge clk);
    check("flush_start_hold", 64'(hold_o), 64'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_start_busy", 64'(busy_o), 64'd0);
    @(posedge clk);
    #1;

    // start_i while busy is ignored: result is the first op only
    run_op(F3_MUL, 32'd7, 32'd6, 5'd3, 32'd42, MUL_LAT, 1'b1, 1'b1, ACT_BUSY, 5, MUL_LAT + 8);

    // Reset in cycle 5 of a MUL
    run_op(F3_MUL, 32'd9, 32'd9, 5'd22, 32'd0, MUL_LAT, 1'b0, 1'b0, ACT_RST, 5, 6);

    // Unit still works after reset
    op(F3_MUL, 32'd3, 32'd4, 5'd23, 32'd12, MUL_LAT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
